// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one iterative mul/div unit between NREQ requesters.
// Operands are latched at grant; the result (or a timeout error) returns to the owner.
module muldiv_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [3*NREQ-1:0] req_op_i,
  input  logic [DW*NREQ-1:0] req_a_i,
  input  logic [DW*NREQ-1:0] req_b_i,
  input  logic [NREQ-1:0]   req_cancel_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   resp_valid_o,
  output logic [DW-1:0]     resp_data_o,
  output logic              resp_err_o,
  output logic              busy_o,
  output logic              unit_start_o,
  output logic [2:0]        unit_op_o,
  output logic [DW-1:0]     unit_a_o,
  output logic [DW-1:0]     unit_b_o,
  input  logic              unit_ready_i,
  input  logic [DW-1:0]     unit_result_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2, ABORT = 2'd3} state_t;

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   owner_r, ptr_r, pick_s;
  logic [5:0]      timer_r;
  logic [NREQ-1:0] elig_s, grant_s, owner_oh_s;
  logic            found_s, cancel_own_s, timeout_s;
  logic [NREQ-1:0] resp_valid_r;
  logic [DW-1:0]   resp_data_r, unit_a_r, unit_b_r;
  logic            resp_err_r, busy_r, unit_start_r;
  logic [2:0]      unit_op_r;

  // Round-robin search: first eligible requester after the last owner
  always_comb begin
    elig_s  = req_valid_i & ~req_cancel_i;
    found_s = 1'b0;
    pick_s  = ptr_r;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && elig_s[(int'(ptr_r) + k) % NREQ]) begin
        found_s = 1'b1;
        pick_s  = PW'((int'(ptr_r) + k) % NREQ);
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Owner decode and run-phase abort/timeout conditions
  always_comb begin
    owner_oh_s          = {NREQ{1'b0}};
    owner_oh_s[owner_r] = 1'b1;
    cancel_own_s        = req_cancel_i[owner_r];
    timeout_s           = (timer_r == 6'(TIMEOUT));
  end

  // Next-state logic and combinational grant
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = {NREQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (found_s && !rst) begin
          state_nxt_s     = RUN;
          grant_s[pick_s] = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // owner flush beats a same-cycle ready; ready beats timeout
        if (cancel_own_s) begin
          state_nxt_s = ABORT;
        end else if (unit_ready_i) begin
          state_nxt_s = RESP;
        end else if (timeout_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RESP:    state_nxt_s = IDLE;
      ABORT:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, pointer/timer and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r      <= {PW{1'b0}};
      ptr_r        <= PW'(NREQ - 1);
      timer_r      <= 6'd0;
      resp_valid_r <= {NREQ{1'b0}};
      resp_data_r  <= {DW{1'b0}};
      resp_err_r   <= 1'b0;
      busy_r       <= 1'b0;
      unit_start_r <= 1'b0;
      unit_op_r    <= 3'd0;
      unit_a_r     <= {DW{1'b0}};
      unit_b_r     <= {DW{1'b0}};
    end else begin
      busy_r       <= (state_nxt_s != IDLE);
      unit_start_r <= (state_nxt_s == RUN);
      resp_valid_r <= (state_r == RUN && state_nxt_s == RESP) ? owner_oh_s : {NREQ{1'b0}};
      if (state_r == IDLE && state_nxt_s == RUN) begin
        unit_op_r <= req_op_i[3*int'(pick_s) +: 3];
        unit_a_r  <= req_a_i[DW*int'(pick_s) +: DW];
        unit_b_r  <= req_b_i[DW*int'(pick_s) +: DW];
        owner_r   <= pick_s;
        ptr_r     <= pick_s;
        timer_r   <= 6'd0;
      end else if (state_r == RUN) begin
        timer_r <= timer_r + 6'd1;
      end
      if (state_r == RUN && state_nxt_s == RESP) begin
        resp_data_r <= unit_ready_i ? unit_result_i : {DW{1'b0}};
        resp_err_r  <= !unit_ready_i;
      end
    end
  end

  assign grant_o      = grant_s;
  assign resp_valid_o = resp_valid_r;
  assign resp_data_o  = resp_data_r;
  assign resp_err_o   = resp_err_r;
  assign busy_o       = busy_r;
  assign unit_start_o = unit_start_r;
  assign unit_op_o    = unit_op_r;
  assign unit_a_o     = unit_a_r;
  assign unit_b_o     = unit_b_r;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: the bench plays the execution unit and keeps a
// transaction-level model (pending set, rr pointer, last response) of the arbiter.
module tb_muldiv_arbiter;
  localparam int NREQ    = 2;
  localparam int DW      = 32;
  localparam int TIMEOUT = 63;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid_i, req_cancel_i, grant_o, resp_valid_o;
  logic [3*NREQ-1:0] req_op_i;
  logic [DW*NREQ-1:0] req_a_i, req_b_i;
  logic [DW-1:0]     resp_data_o, unit_a_o, unit_b_o, unit_result_i;
  logic              resp_err_o, busy_o, unit_start_o, unit_ready_i;
  logic [2:0]        unit_op_o;

  muldiv_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_cancel_i(req_cancel_i), .grant_o(grant_o), .resp_valid_o(resp_valid_o),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
    .unit_start_o(unit_start_o), .unit_op_o(unit_op_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_ready_i(unit_ready_i), .unit_result_i(unit_result_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [NREQ-1:0] pend_m;
  logic [2:0]      op_m [NREQ];
  logic [DW-1:0]   a_m  [NREQ];
  logic [DW-1:0]   b_m  [NREQ];
  int              ptr_m;
  logic [DW-1:0]   data_m;
  logic            err_m;

  localparam int K_READY = 0, K_CANCEL = 1, K_BOTH = 2, K_TIMEOUT = 3, K_RESET = 4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // winner = first eligible requester after the previous owner, wrapping
  function automatic int pick(input logic [NREQ-1:0] elig);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic add_req(input int i, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend_m[i] = 1'b1;
    op_m[i]   = op;
    a_m[i]    = a;
    b_m[i]    = b;
    req_valid_i[i]          = 1'b1;
    req_op_i[3*i +: 3]      = op;
    req_a_i[DW*i +: DW]     = a;
    req_b_i[DW*i +: DW]     = b;
  endtask

  task automatic ensure(input int i);
    if (!pend_m[i]) add_req(i, 3'($urandom_range(0, 7)), $urandom(), $urandom());
  endtask

  // One transaction, entered at the start of an IDLE cycle and left at the start of the next one.
  task automatic do_op(input logic [NREQ-1:0] nc, input int kind, input int lat, input logic [DW-1:0] res);
    int w;
    int endk;
    logic [NREQ-1:0] woh;
    req_cancel_i  = nc;
    unit_ready_i  = 1'b0;
    unit_result_i = res;
    w = pick(pend_m & ~nc);
    if (w < 0) return;
    woh = oh(w);
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("grant", grant_o, woh);
    chk("idle_resp_valid", resp_valid_o, 0);
    chk("idle_start", unit_start_o, 0);
    chk("hold_data", resp_data_o, data_m);
    chk("hold_err", resp_err_o, err_m);
    tick();
    ptr_m          = w;
    pend_m[w]      = 1'b0;
    req_valid_i[w] = 1'b0;
    req_cancel_i   = nc & ~woh;
    endk = (kind == K_TIMEOUT) ? TIMEOUT + 1 : lat;
    for (int k = 1; k <= endk; k++) begin
      if (k == endk) begin
        case (kind)
          K_READY:  unit_ready_i = 1'b1;
          K_CANCEL: req_cancel_i[w] = 1'b1;
          K_BOTH:   begin unit_ready_i = 1'b1; req_cancel_i[w] = 1'b1; end
          K_RESET:  rst = 1'b1;
          default:  ;
        endcase
      end
      @(negedge clk);
      chk("run_start", unit_start_o, 1);
      chk("run_busy", busy_o, 1);
      chk("run_no_grant", grant_o, 0);
      chk("run_resp_valid", resp_valid_o, 0);
      if (k == 1) begin
        chk("latched_op", unit_op_o, op_m[w]);
        chk("latched_a", unit_a_o, a_m[w]);
        chk("latched_b", unit_b_o, b_m[w]);
      end
      tick();
      unit_ready_i = 1'b0;
      req_cancel_i = nc & ~woh;
    end
    if (kind == K_RESET) begin
      rst          = 1'b0;
      req_valid_i  = '0;
      req_cancel_i = '0;
      pend_m       = '0;
      ptr_m        = NREQ - 1;
      data_m       = '0;
      err_m        = 1'b0;
      @(negedge clk);
      chk("rst_grant", grant_o, 0);
      chk("rst_resp_valid", resp_valid_o, 0);
      chk("rst_data", resp_data_o, 0);
      chk("rst_err", resp_err_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_start", unit_start_o, 0);
      chk("rst_op", unit_op_o, 0);
      chk("rst_a", unit_a_o, 0);
      chk("rst_b", unit_b_o, 0);
      tick();
      return;
    end
    if (kind == K_READY) begin data_m = res; err_m = 1'b0; end
    if (kind == K_TIMEOUT) begin data_m = '0; err_m = 1'b1; end
    @(negedge clk);
    chk("end_resp_valid", resp_valid_o, (kind == K_READY || kind == K_TIMEOUT) ? woh : '0);
    chk("end_start", unit_start_o, 0);
    chk("end_busy", busy_o, 1);
    chk("end_data", resp_data_o, data_m);
    chk("end_err", resp_err_o, err_m);
    tick();
  endtask

  initial begin
    logic [NREQ-1:0] nc;
    int kind, lat, c, r;
    rst = 1'b1;
    req_valid_i = '0; req_cancel_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    unit_ready_i = 1'b0; unit_result_i = '0;
    pend_m = '0; ptr_m = NREQ - 1; data_m = '0; err_m = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_grant", grant_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_start", unit_start_o, 0);
    chk("reset_resp_valid", resp_valid_o, 0);
    chk("reset_data", resp_data_o, 0);
    tick();
    rst = 1'b0;

    // single DIV 100/7 with a 33-cycle unit
    add_req(0, 3'd4, 32'd100, 32'd7);
    do_op('0, K_READY, 33, 32'h0000_000E);

    // reset in the middle of RUN, then both requesters: req0 must win
    ensure(1);
    do_op('0, K_RESET, 5, 32'd0);
    for (int n = 0; n < 4; n++) begin
      ensure(0);
      ensure(1);
      do_op('0, K_READY, $urandom_range(1, 12), $urandom());
    end

    // owner flush at RUN cycle 10, flush racing ready, then a normal op
    ensure(0);
    do_op('0, K_CANCEL, 10, 32'hDEAD_BEEF);
    ensure(1);
    do_op('0, K_BOTH, 7, 32'hCAFE_F00D);
    ensure(0);
    do_op('0, K_READY, 3, 32'h1234_5678);

    // unit never answers; then ready on the exact timeout cycle wins
    ensure(1);
    do_op('0, K_TIMEOUT, 0, 32'hFFFF_FFFF);
    ensure(0);
    do_op('0, K_READY, TIMEOUT + 1, 32'h0BAD_F00D);

    // flushed non-owner is skipped even when it is next in turn
    ensure(0);
    ensure(1);
    do_op(oh((ptr_m + 1) % NREQ), K_READY, 4, 32'h0000_0042);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_m[i] && $urandom_range(0, 1) == 1) ensure(i);
      end
      if (pend_m == '0) ensure($urandom_range(0, NREQ - 1));
      nc = '0;
      if ($urandom_range(0, 3) == 0) begin
        c = $urandom_range(0, NREQ - 1);
        nc[c] = 1'b1;
        if ((pend_m & ~nc) == '0) nc = '0;
      end
      r = $urandom_range(0, 9);
      kind = (r < 6) ? K_READY : (r < 8) ? K_CANCEL : (r == 8) ? K_BOTH : K_TIMEOUT;
      lat  = (kind == K_READY) ? $urandom_range(1, TIMEOUT + 1) : $urandom_range(1, 40);
      do_op(nc, kind, lat, $urandom());
    end

    req_valid_i = '0;
    req_cancel_i = '0;
    @(negedge clk);
    chk("final_idle", busy_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
